// File: rtl/msk_share_encoder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | msk_share_encoder                                                       |
// | Encodes an unmasked W-bit word into a d-share bit-interleaved Boolean   |
// | sharing. Share 0 absorbs one random share per cycle through a register. |
// | Optional: MSK_ENC_ZEROIZE_EN clears all shares after the handshake.     |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module msk_share_encoder #(
  parameter int d = 2,
  parameter int W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [W-1:0]       in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [(d-1)*W-1:0] rnd,
  input  logic               rnd_valid,
  output logic               rnd_ready,
  output logic [d*W-1:0]     out_sh,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int                c_cnt_w   = $clog2(d) + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_first = c_cnt_w'(2);
  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(d - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIX  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [W-1:0]       r_sh     [d];
  logic [W-1:0]       w_sh_nxt [d];
  logic [W-1:0]       w_mix_sel;
  logic               w_idle;

  assign w_idle    = (r_state == ST_IDLE);
  assign in_ready  = en & ~rst & w_idle;
  assign rnd_ready = en & ~rst & w_idle;
  assign out_valid = (r_state == ST_OUT);

  // Share selected by the mix counter; only indices 2..d-1 are ever visited.
  always_comb begin
    w_mix_sel = '0;
    for (int k = 2; k < d; k++) begin
      if (r_cnt == c_cnt_w'(k)) begin
        w_mix_sel = r_sh[k];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    for (int k = 0; k < d; k++) begin
      w_sh_nxt[k] = r_sh[k];
    end

    if (en) begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && rnd_valid) begin
            for (int k = 1; k < d; k++) begin
              w_sh_nxt[k] = rnd[(k-1)*W +: W];
            end
            w_sh_nxt[0] = in_data ^ rnd[W-1:0];
            w_cnt_nxt   = c_cnt_first;
            w_state_nxt = (d == 2) ? ST_OUT : ST_MIX;
          end
        end
        ST_MIX: begin
          w_sh_nxt[0] = r_sh[0] ^ w_mix_sel;
          w_cnt_nxt   = r_cnt + c_cnt_one;
          if (r_cnt == c_cnt_last) begin
            w_state_nxt = ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            w_state_nxt = ST_IDLE;
`ifdef MSK_ENC_ZEROIZE_EN
            for (int k = 0; k < d; k++) begin
              w_sh_nxt[k] = '0;
            end
`endif
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      for (int k = 0; k < d; k++) begin
        r_sh[k] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      for (int k = 0; k < d; k++) begin
        r_sh[k] <= w_sh_nxt[k];
      end
    end
  end

  // Bit i of share s lands at out_sh[i*d + s].
  generate
    for (genvar i = 0; i < W; i++) begin : g_bit
      for (genvar s = 0; s < d; s++) begin : g_share
        assign out_sh[i*d + s] = r_sh[s][i];
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_msk_share_encoder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_msk_share_encoder                                                    |
// | Randomized bench for d=2,3,4 (W=8) against a share-level reference.     |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_msk_share_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en   [3];
  logic        iv   [3];
  logic        rv   [3];
  logic        ordy [3];
  logic [7:0]  din  [3];
  logic [23:0] rnd  [3];
  wire  [2:0]  ir;
  wire  [2:0]  rr;
  wire  [2:0]  ov;
  wire  [15:0] osh0;
  wire  [23:0] osh1;
  wire  [31:0] osh2;

  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] last_sh;

  always #5 clk = ~clk;

  msk_share_encoder #(.d(2), .W(8)) u_d2 (
    .clk(clk), .rst(rst), .en(en[0]), .in_data(din[0]), .in_valid(iv[0]),
    .in_ready(ir[0]), .rnd(rnd[0][7:0]), .rnd_valid(rv[0]), .rnd_ready(rr[0]),
    .out_sh(osh0), .out_valid(ov[0]), .out_ready(ordy[0]));

  msk_share_encoder #(.d(3), .W(8)) u_d3 (
    .clk(clk), .rst(rst), .en(en[1]), .in_data(din[1]), .in_valid(iv[1]),
    .in_ready(ir[1]), .rnd(rnd[1][15:0]), .rnd_valid(rv[1]), .rnd_ready(rr[1]),
    .out_sh(osh1), .out_valid(ov[1]), .out_ready(ordy[1]));

  msk_share_encoder #(.d(4), .W(8)) u_d4 (
    .clk(clk), .rst(rst), .en(en[2]), .in_data(din[2]), .in_valid(iv[2]),
    .in_ready(ir[2]), .rnd(rnd[2]), .rnd_valid(rv[2]), .rnd_ready(rr[2]),
    .out_sh(osh2), .out_valid(ov[2]), .out_ready(ordy[2]));

  function automatic logic [31:0] osh(input int u);
    case (u)
      0:       return {16'b0, osh0};
      1:       return {8'b0, osh1};
      default: return osh2;
    endcase
  endfunction

  // Reference: shares 1..D-1 are the random chunks, share 0 closes the XOR to data.
  function automatic logic [31:0] model(input int D, input logic [7:0] data,
                                        input logic [23:0] r);
    logic [7:0]  sh [4];
    logic [31:0] p;
    p     = '0;
    sh[0] = data;
    for (int s = 1; s < 4; s++) sh[s] = '0;
    for (int s = 1; s < D; s++) begin
      sh[s] = r[(s-1)*8 +: 8];
      sh[0] = sh[0] ^ sh[s];
    end
    for (int i = 0; i < 8; i++)
      for (int s = 0; s < D; s++)
        p[i*D + s] = sh[s][i];
    return p;
  endfunction

  function automatic logic [7:0] deint(input logic [31:0] p, input int D, input int s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = p[i*D + s];
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full word: accept, optional en stall in MIX, hold in OUT, en=0 probe, handshake.
  task automatic do_word(input int u, input logic [7:0] data, input logic [23:0] r,
                         input int stall_len, input int hold);
    int          D;
    int          lat;
    logic [31:0] exp;
    D = u + 2;
    din[u] = data; rnd[u] = r; iv[u] = 1'b1; rv[u] = 1'b1;
    check("in_ready_idle", {31'b0, ir[u]}, 1);
    check("rnd_ready_idle", {31'b0, rr[u]}, 1);
    tick();
    iv[u] = 1'b0; rv[u] = 1'b0;
    lat = 1;
    while (!ov[u] && lat < 30) begin
      check("busy_in_ready", {31'b0, ir[u]}, 0);
      if (lat == 1 && stall_len > 0) begin
        en[u] = 1'b0;
        repeat (stall_len) begin tick(); lat++; end
        en[u] = 1'b1;
      end else begin
        tick();
        lat++;
      end
    end
    check("latency", lat, D - 1 + stall_len);
    exp = model(D, data, r);
    check("out_sh", osh(u), exp);
    check("out_rnd_ready", {31'b0, rr[u]}, 0);
    last_sh = osh(u);
    ordy[u] = 1'b0;
    repeat (hold) begin
      tick();
      check("hold_valid", {31'b0, ov[u]}, 1);
      check("hold_sh", osh(u), exp);
      check("hold_in_ready", {31'b0, ir[u]}, 0);
    end
    ordy[u] = 1'b1; en[u] = 1'b0;
    tick();
    check("en0_valid", {31'b0, ov[u]}, 1);
    check("en0_sh", osh(u), exp);
    en[u] = 1'b1;
    tick();
    ordy[u] = 1'b0;
    check("post_valid", {31'b0, ov[u]}, 0);
    check("post_in_ready", {31'b0, ir[u]}, 1);
`ifdef MSK_ENC_ZEROIZE_EN
    check("post_sh_zero", osh(u), 0);
`else
    check("post_sh_keep", osh(u), exp);
`endif
  endtask

  task automatic reset_mid(input int u);
    din[u] = 8'h5A; rnd[u] = 24'h123456; iv[u] = 1'b1; rv[u] = 1'b1;
    tick();
    iv[u] = 1'b0; rv[u] = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_valid", {31'b0, ov[u]}, 0);
    check("rst_sh", osh(u), 0);
    check("rst_in_ready", {31'b0, ir[u]}, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rel_in_ready", {31'b0, ir[u]}, 1);
    tick();
    check("rel_valid", {31'b0, ov[u]}, 0);
    check("rel_in_ready2", {31'b0, ir[u]}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stl;
    logic [23:0] rr_v;
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      en[u] = 1'b1; iv[u] = 1'b0; rv[u] = 1'b0; ordy[u] = 1'b0;
      din[u] = '0; rnd[u] = '0;
    end
    tick(); tick();
    for (int u = 0; u < 3; u++) begin
      check("reset_valid", {31'b0, ov[u]}, 0);
      check("reset_sh", osh(u), 0);
      check("reset_in_ready", {31'b0, ir[u]}, 0);
      check("reset_rnd_ready", {31'b0, rr[u]}, 0);
    end
    rst = 1'b0;
    tick();
    for (int u = 0; u < 3; u++) check("first_in_ready", {31'b0, ir[u]}, 1);

    do_word(0, 8'hA5, 24'h00003C, 0, 0);
    check("d2_share0", {24'b0, deint(last_sh, 2, 0)}, 32'h99);
    check("d2_share1", {24'b0, deint(last_sh, 2, 1)}, 32'h3C);

    do_word(1, 8'hFF, 24'h00F00F, 0, 0);
    check("d3_share0", {24'b0, deint(last_sh, 3, 0)}, 32'h00);
    check("d3_share1", {24'b0, deint(last_sh, 3, 1)}, 32'h0F);
    check("d3_share2", {24'b0, deint(last_sh, 3, 2)}, 32'hF0);

    do_word(0, 8'h3E, 24'h0000C1, 0, 5);

    din[0] = 8'h77; rnd[0] = 24'h0000E4; iv[0] = 1'b1; rv[0] = 1'b0;
    repeat (3) begin
      tick();
      check("partial_in_ready", {31'b0, ir[0]}, 1);
      check("partial_rnd_ready", {31'b0, rr[0]}, 1);
      check("partial_valid", {31'b0, ov[0]}, 0);
    end
    do_word(0, 8'h77, 24'h0000E4, 0, 0);
    tick();
    check("single_accept", {31'b0, ov[0]}, 0);

    do_word(2, 8'hC3, 24'h9A5E17, 2, 1);

    reset_mid(0);
    reset_mid(1);
    reset_mid(2);

    for (int u = 0; u < 3; u++) begin
      for (int n = 0; n < 8; n++) begin
        stl  = (u == 0) ? 0 : int'($urandom_range(0, 2));
        rr_v = 24'($urandom);
        do_word(u, 8'($urandom), rr_v, stl, int'($urandom_range(0, 3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msk_share_encoder.md
# msk_share_encoder

Masking encoder that turns an unmasked W-bit word into a d-share Boolean sharing for the masked Clyde datapath. It sits at the boundary between the unmasked key/state loader and the masked S-box and L-box gadgets. It is the producer of the bit-interleaved sharings that the masked AND gadgets consume. Share 0 is accumulated one random share per cycle through a register, so no cycle combines more than one fresh random share with the running value.

## Interface
Parameters:
- d, 2, number of shares (d >= 2)
- W, 32, word width in bits

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  global enable; when 0, every register holds and both readys read 0
- in_data  in  W  unmasked word
- in_valid  in  1  in_data is valid
- in_ready  out  1  encoder accepts in_data
- rnd  in  (d-1)*W  fresh randomness; chunk k (k=1..d-1) is rnd[(k-1)*W +: W]
- rnd_valid  in  1  rnd is valid
- rnd_ready  out  1  encoder consumes rnd
- out_sh  out  d*W  sharing; bit i of share s is at out_sh[i*d + s]
- out_valid  out  1  out_sh is valid
- out_ready  in  1  downstream accepts out_sh

## Operation
- State registers: state (IDLE, MIX, OUT), counter cnt of width clog2(d)+1, share registers sh[0..d-1] of W bits each.
- in_ready = rnd_ready = en & (state==IDLE). Both are combinational from state only; they never depend on the valid inputs.
- Accept occurs when en & IDLE & in_valid & rnd_valid. On accept:
  - sh[k] <= rnd chunk k for k=1..d-1
  - sh[0] <= in_data ^ chunk 1
  - cnt <= 2
  - next state: OUT if d==2, else MIX
- in_valid without rnd_valid, or rnd_valid without in_valid: no accept and nothing consumed. The bench checks that both readys stay 1 in this case.
- MIX, with en=1 each cycle:
  - sh[0] <= sh[0] ^ sh[cnt]
  - cnt <= cnt+1
  - when cnt==d-1, next state is OUT
- OUT: out_valid=1. When out_ready is high, go to IDLE.
- out_valid = (state==OUT). out_sh is wired directly from the sh registers, so no combinational XOR sits on the output.
- Invariant in OUT: XOR over all shares equals in_data.
- No overlap: a new word is accepted only in IDLE. Minimum period is d cycles per word.
- en=0 freezes state, cnt and sh in any state. out_valid keeps its value, but no handshake completes while en=0.
- A reset asserted mid-operation aborts the word immediately. The word is not resumed or replayed.

## Timing
- Reset values:
  - state=IDLE, cnt=0, all sh=0
  - out_sh=0, out_valid=0
  - in_ready=rnd_ready=0 while rst=1; they read 1 on the first cycle after release if en=1
- Latency from the accept edge to out_valid=1 is d-1 cycles (d=2: the next cycle).
- out_valid stays high and out_sh stays stable until the cycle in which out_ready=1 and en=1.
- Back-to-back: a handshake at OUT edge t allows the next accept at edge t+1.

## Configuration
- MSK_ENC_ZEROIZE_EN defined:
  - on the OUT→IDLE transition, all sh registers are cleared to 0
  - out_sh reads 0 whenever out_valid=0, except transiently during MIX, where share 0 is always masked
- Not defined: sh registers keep the last sharing after the handshake until the next accept.

## Test plan
- Reset, d=2, W=8: assert rst mid-MIX or mid-OUT → next cycle out_valid=0, out_sh=0; after release with en=1, in_ready=1.
- d=2, W=8, in_data=0xA5, rnd=0x3C, both valid → one cycle later out_valid=1, share0=0x99, share1=0x3C; out_ready=1 → IDLE; next accept possible the following cycle.
- d=3, W=8, in_data=0xFF, chunk1=0x0F, chunk2=0xF0 → out_valid two cycles after accept, share0=0x00, share1=0x0F, share2=0xF0; in_ready=0 during MIX and OUT.
- Backpressure, d=2: hold out_ready=0 for 5 cycles in OUT → out_sh stable and in_ready=0 throughout; single handshake when out_ready rises.
- Partial valids: in_valid=1, rnd_valid=0 for 3 cycles, then rnd_valid=1 → exactly one accept, on the cycle both are high.
- en=0 for 2 cycles during MIX (d=4) → latency extends from 3 to 5 cycles and the final sharing is unchanged. With MSK_ENC_ZEROIZE_EN defined, all shares read 0 after the handshake; without it, they retain their values.
